// File: rtl/pulse_meas_pkg.sv
// Shared definitions for the pulse timing path (single-shot generator and width capture).
// Both blocks use the same default width so generated and measured tick counts compare directly.
package pulse_meas_pkg;

    localparam int PMEAS_N_DEFAULT = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t ARMED   = 2'd1;
    localparam state_t MEASURE = 2'd2;
    localparam state_t DONE    = 2'd3;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous input, followed by a previous-sample flop
// that yields single-cycle rise/fall strobes on the synchronised signal.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_sig_s,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sig_s = r_sync[SYNC_STAGES-1];
    assign o_rise  = o_sig_s & ~r_prev;
    assign o_fall  = ~o_sig_s & r_prev;

endmodule

// File: rtl/pulse_width_capture.sv
// Measures how many time-base ticks an asynchronous pulse lasts and hands the result
// to the consumer through a valid/ack handshake, saturating at 2^N-1 with an overflow flag.
module pulse_width_capture
    import pulse_meas_pkg::*;
#(
    parameter int N           = PMEAS_N_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic         arm,
    input  logic         sig_in,
    input  logic         ack,
    output logic         busy,
    output logic         valid,
    output logic [N-1:0] width,
    output logic         overflow
);

    localparam logic [N-1:0] CNT_MAX = '1;

    state_t       r_state;
    state_t       w_next;
    logic         w_sig_s;
    logic         w_rise;
    logic         w_fall;
    logic         w_busy_next;
    logic         w_valid_next;
    logic [N-1:0] r_cnt;
    logic         r_ovf;
    logic         r_busy;
    logic         r_valid;
    logic [N-1:0] r_width;
    logic         r_overflow;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_sig   (sig_in),
        .o_sig_s (w_sig_s),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_busy_next;
            r_valid <= w_valid_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (arm)    w_next = ARMED;
            ARMED:   if (w_rise) w_next = MEASURE;
            MEASURE: if (w_fall) w_next = DONE;
            DONE:    if (ack)    w_next = IDLE;
            default:             w_next = IDLE;
        endcase
    end

    // Flags are computed from the next state so busy/valid come straight off flops.
    always_comb begin
        w_busy_next  = (w_next == ARMED) || (w_next == MEASURE);
        w_valid_next = (w_next == DONE);
    end

    // A tick on the fall cycle is excluded because sig_s is already low there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_width    <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (arm) begin
                        r_cnt <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                ARMED: begin
                    if (w_rise) begin
                        r_cnt <= N'(tick);
                        r_ovf <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (w_fall) begin
                        r_width    <= r_cnt;
                        r_overflow <= r_ovf;
                    end else if (tick && w_sig_s) begin
                        if (r_cnt == CNT_MAX) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + N'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign valid    = r_valid;
    assign width    = r_width;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_pulse_width_capture.sv
// Randomised scoreboard bench for pulse_width_capture: expected widths come from counting
// the bench's own tick history over the synchronised pulse window.
module tb_pulse_width_capture;

    localparam int N      = 8;
    localparam int S      = 2;
    localparam int MAXW   = 255;
    localparam int HIST   = 16384;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tick;
    logic         arm;
    logic         sig_in;
    logic         ack;
    logic         busy;
    logic         valid;
    logic [N-1:0] width;
    logic         overflow;

    typedef struct {
        int w;
        bit ovf;
        int doneEdge;
    } exp_t;

    exp_t expQ[$];
    exp_t cur;
    int   total = 0;
    int   bad = 0;
    int   edgeIdx = 0;
    int   tickMode = 0;
    bit   tickHist[HIST];
    bit   prevValid = 1'b0;

    always #5 clk = ~clk;

    pulse_width_capture #(
        .N           (N),
        .SYNC_STAGES (S)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .arm      (arm),
        .sig_in   (sig_in),
        .ack      (ack),
        .busy     (busy),
        .valid    (valid),
        .width    (width),
        .overflow (overflow)
    );

    task automatic checkOutput(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // One clock: choose tick for the coming edge, remember it, return at the following negedge.
    task automatic tickCycle();
        case (tickMode)
            0:       tick = 1'b1;
            1:       tick = ((edgeIdx % 4) == 0);
            default: tick = 1'($urandom_range(0, 1));
        endcase
        tickHist[edgeIdx % HIST] = tick;
        @(posedge clk);
        edgeIdx++;
        @(negedge clk);
    endtask

    // sig_in sampled high on edges a..a+len-1 is seen as sig_s high for ticks on edges a+S..a+len-1+S.
    function automatic int modelCount(input int a, input int len);
        int c = 0;
        for (int j = a + S; j <= a + len - 1 + S; j++) c += int'(tickHist[j % HIST]);
        return c;
    endfunction

    task automatic waitAndAck(input int hold, input bit armToo);
        int n = 0;
        while (!valid && n < 40) begin
            tickCycle();
            n++;
        end
        if (!valid) begin
            checkOutput("valid_timeout", 0, 1);
            return;
        end
        repeat (hold) tickCycle();
        ack = 1'b1;
        arm = armToo;
        tickCycle();
        ack = 1'b0;
        arm = 1'b0;
        checkOutput("valid_after_ack", int'(valid), 0);
        checkOutput("busy_after_ack", int'(busy), 0);
        if (armToo) begin
            tickCycle();
            checkOutput("busy_arm_with_ack", int'(busy), 0);
            checkOutput("valid_arm_with_ack", int'(valid), 0);
        end
    endtask

    task automatic applyStimulus(input int len, input bit withArm, input bit expectResult,
                                 input int armMidAt, input int alignPhase, input int hold,
                                 input bit armWithAck);
        int a;
        int cnt;
        if (withArm) begin
            arm = 1'b1;
            tickCycle();
            arm = 1'b0;
            checkOutput("busy_after_arm", int'(busy), 1);
        end
        repeat (3) tickCycle();
        if (alignPhase >= 0) begin
            while (((edgeIdx + len + S) % 4) != alignPhase) tickCycle();
        end
        a = edgeIdx;
        sig_in = 1'b1;
        for (int i = 0; i < len; i++) begin
            if (i == armMidAt) arm = 1'b1;
            tickCycle();
            arm = 1'b0;
        end
        sig_in = 1'b0;
        repeat (S) tickCycle();
        if (expectResult) begin
            cnt = modelCount(a, len);
            expQ.push_back('{w: (cnt > MAXW) ? MAXW : cnt, ovf: (cnt > MAXW), doneEdge: edgeIdx + 1});
            waitAndAck(hold, armWithAck);
        end else begin
            repeat (6) tickCycle();
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prevValid = 1'b0;
        end else begin
            if (valid && !prevValid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_valid", 1, 0);
                end else begin
                    cur = expQ.pop_front();
                    checkOutput("width", int'(width), cur.w);
                    checkOutput("overflow", int'(overflow), int'(cur.ovf));
                    checkOutput("valid_latency_edge", edgeIdx, cur.doneEdge);
                    checkOutput("busy_at_done", int'(busy), 0);
                end
            end else if (valid) begin
                checkOutput("width_held", int'(width), cur.w);
                checkOutput("overflow_held", int'(overflow), int'(cur.ovf));
            end
            prevValid = valid;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        tick   = 1'b0;
        arm    = 1'b0;
        sig_in = 1'b0;
        ack    = 1'b0;
        repeat (3) tickCycle();
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_valid", int'(valid), 0);
        checkOutput("reset_width", int'(width), 0);
        checkOutput("reset_overflow", int'(overflow), 0);
        rst_n = 1'b1;
        tickCycle();

        tickMode = 0;
        applyStimulus(10, 1, 1, -1, -1, 0, 0);

        tickMode = 1;
        applyStimulus(40, 1, 1, -1, -1, 20, 0);

        tickMode = 0;
        applyStimulus(300, 1, 1, -1, -1, 1, 0);
        applyStimulus(5, 1, 1, -1, -1, 0, 0);
        applyStimulus(255, 1, 1, -1, -1, 0, 0);
        applyStimulus(256, 1, 1, -1, -1, 0, 0);

        applyStimulus(8, 0, 0, -1, -1, 0, 0);
        checkOutput("no_arm_busy", int'(busy), 0);
        checkOutput("no_arm_valid", int'(valid), 0);

        sig_in = 1'b1;
        repeat (4) tickCycle();
        arm = 1'b1;
        tickCycle();
        arm = 1'b0;
        checkOutput("busy_armed_high", int'(busy), 1);
        repeat (5) tickCycle();
        sig_in = 1'b0;
        repeat (4) tickCycle();
        checkOutput("busy_still_armed", int'(busy), 1);
        checkOutput("valid_still_low", int'(valid), 0);
        applyStimulus(7, 0, 1, -1, -1, 0, 0);

        tickMode = 2;
        applyStimulus(12, 1, 1, 5, -1, 2, 0);

        tickMode = 0;
        arm = 1'b1;
        tickCycle();
        arm = 1'b0;
        repeat (3) tickCycle();
        sig_in = 1'b1;
        repeat (50) tickCycle();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_busy", int'(busy), 0);
        checkOutput("async_rst_valid", int'(valid), 0);
        checkOutput("async_rst_width", int'(width), 0);
        checkOutput("async_rst_overflow", int'(overflow), 0);
        tickCycle();
        tickCycle();
        rst_n = 1'b1;
        repeat (3) tickCycle();
        sig_in = 1'b0;
        repeat (6) tickCycle();
        checkOutput("post_rst_valid", int'(valid), 0);
        checkOutput("post_rst_busy", int'(busy), 0);
        applyStimulus(3, 1, 1, -1, -1, 0, 0);

        tickMode = 1;
        applyStimulus(6, 1, 1, -1, 0, 0, 0);
        applyStimulus(6, 1, 1, -1, 1, 0, 1);

        for (int t = 0; t < 10; t++) begin
            tickMode = $urandom_range(0, 2);
            applyStimulus($urandom_range(1, 40), 1, 1, -1, -1, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        repeat (4) tickCycle();
        if (expQ.size() != 0) checkOutput("scoreboard_drained", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
